// File: rtl/ks_sub_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : ks_sub_pipe
//  Description : Three-stage pipelined Kogge-Stone subtractor.
//                Computes a - b - borrow_in with borrow, zero and signed
//                overflow flags, using elastic valid/ready flow control on
//                both sides.
//  Ports       : clk, rst          - clock, async active-high reset
//                in_valid/in_ready - operand handshake (a, b, borrow_in)
//                out_valid/out_ready - result handshake
//                diff, borrow_out, zero, ovf - registered result and flags
//  Revision    : 1.0 - initial release
// ============================================================================
module ks_sub_pipe #(
    parameter int nbits = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [nbits-1:0] a,
    input  logic [nbits-1:0] b,
    input  logic             borrow_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [nbits-1:0] diff,
    output logic             borrow_out,
    output logic             zero,
    output logic             ovf
);

    localparam int depth = $clog2(nbits);
    localparam int HALF  = depth / 2;

    // ------------------------------------------------------------------
    // Flow control
    // ------------------------------------------------------------------
    logic v1_q, v2_q, v3_q;
    logic adv3, load1, load2, load3;

    assign adv3     = v3_q & out_ready;
    assign load3    = ~v3_q | adv3;
    assign load2    = ~v2_q | (v2_q & load3);
    assign load1    = ~v1_q | (v1_q & load2);
    assign in_ready = load1;

    // ------------------------------------------------------------------
    // Pre-stage: subtract as a + ~b + ~borrow_in.
    // Prefix position 0 holds the carry-in; position i (i>=1) holds bit i-1.
    // Only positions 0..nbits-1 enter the prefix network; the carry out of
    // the top bit is formed separately from the MSB operand bits.
    // ------------------------------------------------------------------
    logic [nbits-1:0] bn;
    logic [nbits-1:0] pbit;
    logic [nbits-2:0] gbit;
    logic [nbits-1:0] g1_d;

    assign bn   = ~b;
    assign pbit = a ^ bn;
    assign gbit = a[nbits-2:0] & bn[nbits-2:0];
    assign g1_d = {gbit, ~borrow_in};

    logic [nbits-1:0] g1_q, pb1_q;
    logic             am1_q, bm1_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q  <= 1'b0;
            g1_q  <= '0;
            pb1_q <= '0;
            am1_q <= 1'b0;
            bm1_q <= 1'b0;
        end else if (load1) begin
            v1_q <= in_valid;
            if (in_valid) begin
                g1_q  <= g1_d;
                pb1_q <= pbit;
                am1_q <= a[nbits-1];
                bm1_q <= b[nbits-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Prefix network. Levels below HALF feed from S1, the rest from S2.
    // Shifting by 2^level lines each position up with its partner j=i-2^level;
    // the low mask keeps P unchanged for positions that pass through.
    // ------------------------------------------------------------------
    logic [nbits-1:0] lvl_g [0:depth];
    logic [nbits-1:0] lvl_p [0:depth];
    logic [nbits-1:0] g2_q, p2_q, pb2_q;
    logic             am2_q, bm2_q;

    assign lvl_g[0] = g1_q;
    assign lvl_p[0] = {pb1_q[nbits-2:0], 1'b0};

    genvar l;
    generate
        for (l = 0; l < depth; l++) begin : g_lvl
            localparam int SH = 2 ** l;
            localparam logic [nbits-1:0] LOW = {{(nbits-SH){1'b0}}, {SH{1'b1}}};
            logic [nbits-1:0] sg, sp;
            if (l == HALF) begin : g_cut
                assign sg = g2_q;
                assign sp = p2_q;
            end else begin : g_chain
                assign sg = lvl_g[l];
                assign sp = lvl_p[l];
            end
            assign lvl_g[l+1] = sg | (sp & (sg << SH));
            assign lvl_p[l+1] = sp & ((sp << SH) | LOW);
        end
    endgenerate

    // Final-level group propagate is not needed for the sum.
    logic unused_p;
    assign unused_p = ^lvl_p[depth];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2_q  <= 1'b0;
            g2_q  <= '0;
            p2_q  <= '0;
            pb2_q <= '0;
            am2_q <= 1'b0;
            bm2_q <= 1'b0;
        end else if (load2) begin
            v2_q <= v1_q;
            if (v1_q) begin
                g2_q  <= lvl_g[HALF];
                p2_q  <= lvl_p[HALF];
                pb2_q <= pb1_q;
                am2_q <= am1_q;
                bm2_q <= bm1_q;
            end
        end
    end

    // ------------------------------------------------------------------
    // Sum and flags. lvl_g[depth][i] is the carry into bit i.
    // ------------------------------------------------------------------
    logic [nbits-1:0] carry;
    logic [nbits-1:0] diff_d;
    logic             cout, borrow_d, zero_d, ovf_d;

    assign carry    = lvl_g[depth];
    assign diff_d   = pb2_q ^ carry;
    assign cout     = (am2_q & ~bm2_q) | (pb2_q[nbits-1] & carry[nbits-1]);
    assign borrow_d = ~cout;
    assign zero_d   = (diff_d == '0);
    assign ovf_d    = (am2_q != bm2_q) && (diff_d[nbits-1] != am2_q);

    logic [nbits-1:0] diff_q;
    logic             borrow_q, zero_q, ovf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v3_q     <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (load3) begin
            v3_q <= v2_q;
            if (v2_q) begin
                diff_q   <= diff_d;
                borrow_q <= borrow_d;
                zero_q   <= zero_d;
                ovf_q    <= ovf_d;
            end
        end
    end

    assign out_valid  = v3_q;
    assign diff       = diff_q;
    assign borrow_out = borrow_q;
    assign zero       = zero_q;
    assign ovf        = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_ks_sub_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ks_sub_pipe
//  Description : Self-checking bench for ks_sub_pipe: directed vectors,
//                streaming, backpressure, random stalls, mid-run reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ks_sub_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [15:0] a, b;
    logic        borrow_in;
    logic        out_valid, out_ready;
    logic [15:0] diff;
    logic        borrow_out, zero, ovf;

    ks_sub_pipe #(.nbits(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .borrow_in  (borrow_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .diff       (diff),
        .borrow_out (borrow_out),
        .zero       (zero),
        .ovf        (ovf)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int n_acc = 0;
    int n_out = 0;
    logic [18:0] sbq [$];

    // {diff, borrow, zero, ovf}
    function automatic logic [18:0] model(input logic [15:0] av, input logic [15:0] bv,
                                          input logic bi);
        logic [16:0] full;
        logic [15:0] d;
        full = {1'b0, av} - {1'b0, bv} - {16'd0, bi};
        d    = full[15:0];
        return {d, full[16], (d == 16'd0), ((av[15] != bv[15]) && (d[15] != av[15]))};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: record transfers at the falling edge, return 1ns after the rising edge.
    task automatic cycle();
        logic [18:0] e;
        @(negedge clk);
        if (in_valid && in_ready) begin
            sbq.push_back(model(a, b, borrow_in));
            n_acc++;
        end
        if (out_valid && out_ready) begin
            n_out++;
            chk("sb_expected", 32'(sbq.size() != 0), 32'd1);
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                chk("sb_result", {13'd0, diff, borrow_out, zero, ovf}, {13'd0, e});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) cycle();
        chk(tag, 32'(sbq.size()), 32'd0);
    endtask

    task automatic directed(input string tag, input logic [15:0] av, input logic [15:0] bv,
                            input logic bi, input logic [18:0] exp);
        a = av; b = bv; borrow_in = bi; in_valid = 1'b1; out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        cycle();
        chk({tag, "_early"}, 32'(out_valid), 32'd0);
        cycle();
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk(tag, {13'd0, diff, borrow_out, zero, ovf}, {13'd0, exp});
    endtask

    logic [15:0] va [0:4];
    logic [15:0] vb [0:4];

    initial begin
        int k, acc0, out0, prev;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; borrow_in = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_outputs", {13'd0, diff, borrow_out, zero, ovf}, 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Directed vectors: {diff, borrow, zero, ovf}
        directed("basic",      16'h0005, 16'h0003, 1'b0, {16'h0002, 3'b000});
        directed("wrap",       16'h0000, 16'h0001, 1'b0, {16'hFFFF, 3'b100});
        directed("ovf_neg",    16'h8000, 16'h0001, 1'b0, {16'h7FFF, 3'b001});
        directed("zero_bin",   16'h1234, 16'h1233, 1'b1, {16'h0000, 3'b010});
        directed("ovf_pos",    16'h7FFF, 16'hFFFF, 1'b0, {16'h8000, 3'b101});
        directed("all_ones",   16'hFFFF, 16'hFFFF, 1'b1, {16'hFFFF, 3'b100});
        directed("min_m_max",  16'h8000, 16'h7FFF, 1'b0, {16'h0001, 3'b001});
        drain("directed_drain");

        // Back-to-back streaming
        out0 = n_out;
        for (int i = 0; i < 100; i++) begin
            a = 16'($urandom); b = 16'($urandom); borrow_in = 1'($urandom);
            in_valid = 1'b1; out_ready = 1'b1;
            chk("stream_in_ready", 32'(in_ready), 32'd1);
            chk("stream_out_valid", 32'(out_valid), 32'(i >= 3));
            cycle();
        end
        drain("stream_drain");
        chk("stream_count", 32'(n_out - out0), 32'd100);

        // Backpressure: capacity 3
        va[0] = 16'h0100; va[1] = 16'h0200; va[2] = 16'h0300; va[3] = 16'h0400; va[4] = 16'h0500;
        vb[0] = 16'h0001; vb[1] = 16'h0002; vb[2] = 16'h0003; vb[3] = 16'h0004; vb[4] = 16'h0005;
        acc0 = n_acc; out0 = n_out; k = 0;
        out_ready = 1'b0;
        for (int t = 0; t < 6; t++) begin
            a = va[k]; b = vb[k]; borrow_in = 1'b0; in_valid = 1'b1;
            prev = n_acc;
            cycle();
            if (n_acc != prev) k++;
        end
        chk("bp_accepted", 32'(n_acc - acc0), 32'd3);
        chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        chk("bp_hold_0", {13'd0, diff, borrow_out, zero, ovf}, {13'd0, 16'h00FF, 3'b000});
        cycle();
        chk("bp_hold_1", {13'd0, diff, borrow_out, zero, ovf}, {13'd0, 16'h00FF, 3'b000});
        out_ready = 1'b1;
        #1;
        chk("bp_ready_rise", 32'(in_ready), 32'd1);
        for (int t = 0; t < 10 && k < 5; t++) begin
            a = va[k]; b = vb[k]; borrow_in = 1'b0; in_valid = 1'b1;
            prev = n_acc;
            cycle();
            if (n_acc != prev) k++;
        end
        drain("bp_drain");
        chk("bp_total_acc", 32'(n_acc - acc0), 32'd5);
        chk("bp_total_out", 32'(n_out - out0), 32'd5);

        // Random bubbles and stalls
        acc0 = n_acc; out0 = n_out;
        for (int i = 0; i < 1000; i++) begin
            a = 16'($urandom); b = 16'($urandom); borrow_in = 1'($urandom);
            in_valid = 1'($urandom); out_ready = 1'($urandom);
            cycle();
        end
        drain("rand_drain");
        chk("rand_count", 32'(n_out - out0), 32'(n_acc - acc0));

        // Reset with three entries in flight
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a = 16'($urandom); b = 16'($urandom); borrow_in = 1'b0; in_valid = 1'b1;
            cycle();
        end
        in_valid = 1'b0;
        chk("rst_pre_valid", 32'(out_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_valid", 32'(out_valid), 32'd0);
        chk("rst_async_outputs", {13'd0, diff, borrow_out, zero, ovf}, 32'd0);
        sbq.delete();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("rst_no_stale", 32'(out_valid), 32'd0);
        end
        directed("post_rst", 16'h00FF, 16'h0100, 1'b0, {16'hFFFF, 3'b100});
        drain("final_drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
